// File: rtl/cam_stream_gen_pkg.sv
// Shared types and constants for the camera stream generator.
// Pattern encodings, frame sequencer states and pixel width.
package cam_stream_gen_pkg;

    localparam int PIX_W = 10;

    typedef enum logic [1:0] {
        PAT_COL_RAMP = 2'd0,
        PAT_ROW_RAMP = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_DIAG     = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LINE,
        ST_HBL,
        ST_TRAIL,
        ST_VBL
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational test-pattern pixel generator.
// Row/col arrive zero-extended to the pixel width.
module cam_pattern_pixel
    import cam_stream_gen_pkg::*;
(
    input  pattern_e         pattern,
    input  logic [PIX_W-1:0] row,
    input  logic [PIX_W-1:0] col,
    input  logic [PIX_W-1:0] frame_cnt,
    output logic [PIX_W-1:0] pixel
);

    always_comb begin
        pixel = '0;
        unique case (pattern)
            PAT_COL_RAMP: pixel = col;
            PAT_ROW_RAMP: pixel = row;
            PAT_CHECKER:  pixel = (col[3] ^ row[3]) ? '1 : '0;
            PAT_DIAG:     pixel = col + row + frame_cnt;
            default:      pixel = '0;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// MT9V034-style parallel video source: FRAME_VALID / LINE_VALID / DATA
// with programmable blanking and a per-frame latched test pattern.
module cam_stream_gen
    import cam_stream_gen_pkg::*;
#(
    parameter int H        = 752,
    parameter int V        = 480,
    parameter int HBLANK   = 94,
    parameter int FV_LEAD  = 4,
    parameter int FV_TRAIL = 4,
    parameter int VBLANK   = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [1:0]       PATTERN,
    output logic             FRAME_VALID,
    output logic             LINE_VALID,
    output logic [PIX_W-1:0] DATA,
    output logic [15:0]      FRAME_COUNT,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam int CW   = (H > 1) ? $clog2(H) : 1;
    localparam int RW   = (V > 1) ? $clog2(V) : 1;
    localparam int BMAX = max_int(max_int(HBLANK, VBLANK), max_int(FV_LEAD, FV_TRAIL));
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(H - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(V - 1);
    localparam logic [BW-1:0] LEAD_LAST  = BW'(FV_LEAD - 1);
    localparam logic [BW-1:0] HBL_LAST   = BW'(HBLANK - 1);
    localparam logic [BW-1:0] TRAIL_LAST = BW'(FV_TRAIL - 1);
    localparam logic [BW-1:0] VBL_LAST   = BW'(VBLANK - 1);

    state_e          state, nxt_state;
    logic [BW-1:0]   cnt, nxt_cnt;
    logic [CW-1:0]   col, nxt_col;
    logic [RW-1:0]   row, nxt_row;
    pattern_e        pat, nxt_pat;
    logic            frame_end;
    logic [PIX_W-1:0] pix;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_col   = col;
        nxt_row   = row;
        nxt_pat   = pat;
        frame_end = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    nxt_state = ST_LEAD;
                    nxt_cnt   = '0;
                    nxt_pat   = pattern_e'(PATTERN);
                end
            end
            ST_LEAD: begin
                if (cnt == LEAD_LAST) begin
                    nxt_state = ST_LINE;
                    nxt_row   = '0;
                    nxt_col   = '0;
                end else begin
                    nxt_cnt = cnt + BW'(1);
                end
            end
            ST_LINE: begin
                if (col == COL_LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = (row == ROW_LAST) ? ST_TRAIL : ST_HBL;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            ST_HBL: begin
                if (cnt == HBL_LAST) begin
                    nxt_state = ST_LINE;
                    nxt_row   = row + RW'(1);
                    nxt_col   = '0;
                end else begin
                    nxt_cnt = cnt + BW'(1);
                end
            end
            ST_TRAIL: begin
                if (cnt == TRAIL_LAST) begin
                    nxt_state = ST_VBL;
                    nxt_cnt   = '0;
                    frame_end = 1'b1;
                end else begin
                    nxt_cnt = cnt + BW'(1);
                end
            end
            ST_VBL: begin
                if (cnt == VBL_LAST) begin
                    nxt_cnt = '0;
                    if (ENABLE) begin
                        nxt_state = ST_LEAD;
                        nxt_pat   = pattern_e'(PATTERN);
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + BW'(1);
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Pixel is computed from the next-cycle position so DATA registers alongside LINE_VALID.
    cam_pattern_pixel u_pixel (
        .pattern   (nxt_pat),
        .row       (PIX_W'(nxt_row)),
        .col       (PIX_W'(nxt_col)),
        .frame_cnt (FRAME_COUNT[PIX_W-1:0]),
        .pixel     (pix)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            col         <= '0;
            row         <= '0;
            pat         <= PAT_COL_RAMP;
            FRAME_VALID <= 1'b0;
            LINE_VALID  <= 1'b0;
            DATA        <= '0;
            FRAME_COUNT <= '0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            col         <= nxt_col;
            row         <= nxt_row;
            pat         <= nxt_pat;
            FRAME_VALID <= (nxt_state inside {ST_LEAD, ST_LINE, ST_HBL, ST_TRAIL});
            LINE_VALID  <= (nxt_state == ST_LINE);
            DATA        <= (nxt_state == ST_LINE) ? pix : '0;
            BUSY        <= (nxt_state != ST_IDLE);
            FRAME_DONE  <= frame_end;
            if (frame_end) begin
                FRAME_COUNT <= FRAME_COUNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen: frame-position reference model,
// checkpoint table, directed corner sequences and randomized control.
module tb_cam_stream_gen;

    typedef struct packed {int h; int v; int hb; int ld; int tr; int vb;} cfg_t;
    typedef struct {bit act; int t; int k; int pat;} ms_t;
    typedef struct {bit fv; bit lv; int data; bit busy; bit done; int cnt;} exp_t;
    typedef struct {int cyc; bit fv; bit lv; int data; bit done; int cnt;} vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en1 = 1'b0, en2 = 1'b0;
    logic [1:0]  pat1 = 2'd0, pat2 = 2'd0;
    logic        fv1, lv1, busy1, done1, fv2, lv2, busy2, done2;
    logic [9:0]  data1, data2;
    logic [15:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    bit start2 = 1'b0;

    cfg_t c1 = '{h: 8,  v: 4,  hb: 3, ld: 2, tr: 2, vb: 5};
    cfg_t c2 = '{h: 32, v: 32, hb: 3, ld: 2, tr: 2, vb: 5};
    ms_t  m1, m2;
    exp_t e1, e2;
    vec_t tbl[16];

    always #5 clk = ~clk;

    cam_stream_gen #(.H(8), .V(4), .HBLANK(3), .FV_LEAD(2), .FV_TRAIL(2), .VBLANK(5)) dut1 (
        .CLK(clk), .RST(rst), .ENABLE(en1), .PATTERN(pat1),
        .FRAME_VALID(fv1), .LINE_VALID(lv1), .DATA(data1),
        .FRAME_COUNT(cnt1), .BUSY(busy1), .FRAME_DONE(done1));

    cam_stream_gen #(.H(32), .V(32), .HBLANK(3), .FV_LEAD(2), .FV_TRAIL(2), .VBLANK(5)) dut2 (
        .CLK(clk), .RST(rst), .ENABLE(en2), .PATTERN(pat2),
        .FRAME_VALID(fv2), .LINE_VALID(lv2), .DATA(data2),
        .FRAME_COUNT(cnt2), .BUSY(busy2), .FRAME_DONE(done2));

    function automatic int frame_len(input cfg_t c);
        return c.ld + c.v * c.h + (c.v - 1) * c.hb + c.tr;
    endfunction

    // Model state is just "cycles since FRAME_VALID rose" plus frame number.
    function automatic ms_t step(input ms_t m, input cfg_t c, input bit r, input bit en, input int pat);
        ms_t n;
        n = m;
        if (r) begin
            n = '{default: 0};
        end else if (!m.act) begin
            if (en) begin
                n.act = 1'b1; n.t = 0; n.pat = pat;
            end
        end else if (m.t == frame_len(c) + c.vb - 1) begin
            if (en) begin
                n.t = 0; n.pat = pat;
            end else begin
                n.act = 1'b0;
            end
        end else begin
            n.t = m.t + 1;
            if (n.t == frame_len(c)) n.k = (m.k + 1) % 65536;
        end
        return n;
    endfunction

    function automatic int pix(input int pat, input int r, input int c, input int k);
        case (pat)
            0: return c % 1024;
            1: return r % 1024;
            2: return (((c / 8) % 2) != ((r / 8) % 2)) ? 1023 : 0;
            default: return (c + r + k) % 1024;
        endcase
    endfunction

    function automatic exp_t expect_out(input ms_t m, input cfg_t c);
        exp_t e;
        int p, u;
        e = '{default: 0};
        e.busy = m.act;
        e.cnt  = m.k;
        e.done = m.act && (m.t == frame_len(c));
        if (m.act && m.t < frame_len(c)) begin
            e.fv = 1'b1;
            p = c.h + c.hb;
            u = m.t - c.ld;
            if (u >= 0 && u < c.v * p - c.hb && (u % p) < c.h) begin
                e.lv   = 1'b1;
                e.data = pix(m.pat, u / p, u % p, m.k % 1024);
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        m1 <= step(m1, c1, rst, en1, int'(pat1));
        m2 <= step(m2, c2, rst, en2, int'(pat2));
    end

    always @(negedge clk) begin
        if (chk_on) begin
            e1 = expect_out(m1, c1);
            e2 = expect_out(m2, c2);
            chk("m1_fv",   int'(fv1),   int'(e1.fv));
            chk("m1_lv",   int'(lv1),   int'(e1.lv));
            chk("m1_data", int'(data1), e1.data);
            chk("m1_busy", int'(busy1), int'(e1.busy));
            chk("m1_done", int'(done1), int'(e1.done));
            chk("m1_cnt",  int'(cnt1),  e1.cnt);
            chk("m2_fv",   int'(fv2),   int'(e2.fv));
            chk("m2_lv",   int'(lv2),   int'(e2.lv));
            chk("m2_data", int'(data2), e2.data);
            chk("m2_busy", int'(busy2), int'(e2.busy));
            chk("m2_done", int'(done2), int'(e2.done));
            chk("m2_cnt",  int'(cnt2),  e2.cnt);
        end
    end

    // Checkerboard on the 32x32 instance: phase flips every 8 columns and at row 8.
    initial begin
        wait (start2);
        tick(10);  chk("chk_r0c7",  int'(data2), 0);
        tick(1);   chk("chk_r0c8",  int'(data2), 1023);
        tick(24);  chk("chk_hbl_lv", int'(lv2), 0);
                   chk("chk_hbl_d", int'(data2), 0);
        tick(248); chk("chk_r8c0",  int'(data2), 1023);
        tick(8);   chk("chk_r8c8",  int'(data2), 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fv_cycles, done_pulses;
        tbl[0]  = '{1,  1, 0, 0, 0, 0};
        tbl[1]  = '{2,  1, 0, 0, 0, 0};
        tbl[2]  = '{3,  1, 1, 0, 0, 0};
        tbl[3]  = '{6,  1, 1, 3, 0, 0};
        tbl[4]  = '{10, 1, 1, 7, 0, 0};
        tbl[5]  = '{11, 1, 0, 0, 0, 0};
        tbl[6]  = '{13, 1, 0, 0, 0, 0};
        tbl[7]  = '{14, 1, 1, 0, 0, 0};
        tbl[8]  = '{21, 1, 1, 7, 0, 0};
        tbl[9]  = '{43, 1, 1, 7, 0, 0};
        tbl[10] = '{44, 1, 0, 0, 0, 0};
        tbl[11] = '{45, 1, 0, 0, 0, 0};
        tbl[12] = '{46, 0, 0, 0, 1, 1};
        tbl[13] = '{47, 0, 0, 0, 0, 1};
        tbl[14] = '{50, 0, 0, 0, 0, 1};
        tbl[15] = '{51, 1, 0, 0, 0, 1};

        tick(3);
        chk_on = 1'b1;
        chk("rst_fv",   int'(fv1),   0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_cnt",  int'(cnt1),  0);
        rst = 1'b0;
        tick(1);

        // Cycle 0: both generators enabled.
        en1 = 1'b1; pat1 = 2'd0;
        en2 = 1'b1; pat2 = 2'd2;
        start2 = 1'b1;
        fv_cycles = 0;
        done_pulses = 0;
        for (int cy = 1; cy <= 51; cy++) begin
            tick(1);
            if (cy <= 50) begin
                fv_cycles += int'(fv1);
                done_pulses += int'(done1);
            end
            for (int i = 0; i < 16; i++) begin
                if (tbl[i].cyc == cy) begin
                    chk($sformatf("tbl%0d_fv", cy),   int'(fv1),   int'(tbl[i].fv));
                    chk($sformatf("tbl%0d_lv", cy),   int'(lv1),   int'(tbl[i].lv));
                    chk($sformatf("tbl%0d_data", cy), int'(data1), tbl[i].data);
                    chk($sformatf("tbl%0d_done", cy), int'(done1), int'(tbl[i].done));
                    chk($sformatf("tbl%0d_cnt", cy),  int'(cnt1),  tbl[i].cnt);
                end
            end
            if (cy == 47) pat1 = 2'd3;
        end
        chk("fv_len", fv_cycles, 45);
        chk("done_pulses", done_pulses, 1);

        // Diagonal pattern: row 2 col 5 equals 7 + frame index.
        tick(29); chk("diag_f1", int'(data1), 8);
        tick(20); chk("vbl_low", int'(fv1), 0);
        tick(1);  chk("f2_rise", int'(fv1), 1);
        tick(29); chk("diag_f2", int'(data1), 9);
        pat1 = 2'd0;

        // Pattern change mid-frame applies only from the next frame.
        tick(36); chk("f3_colramp", int'(data1), 2);
        pat1 = 2'd1;
        tick(51); chk("f4_rowramp_r1", int'(data1), 1);
        en1 = 1'b0;
        tick(19); chk("f4_rowramp_r3", int'(data1), 3);

        // Frame completes after ENABLE drop, then VBL, then IDLE.
        tick(9);  chk("drop_fv_tail", int'(fv1), 1);
        tick(1);  chk("drop_fv_fall", int'(fv1), 0);
                  chk("drop_done", int'(done1), 1);
                  chk("drop_cnt", int'(cnt1), 5);
        tick(4);  chk("drop_vbl_busy", int'(busy1), 1);
        tick(1);  chk("drop_idle_busy", int'(busy1), 0);
        tick(20); chk("drop_no_fv", int'(fv1), 0);
        en1 = 1'b1; pat1 = 2'd0;

        // Reset in the middle of row 2.
        tick(28); chk("pre_rst_lv", int'(lv1), 1);
                  chk("pre_rst_data", int'(data1), 3);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_fv", int'(fv1), 0);
        chk("rst_mid_lv", int'(lv1), 0);
        chk("rst_mid_data", int'(data1), 0);
        chk("rst_mid_busy", int'(busy1), 0);
        chk("rst_mid_cnt", int'(cnt1), 0);
        chk("rst_mid_done", int'(done1), 0);
        rst = 1'b0;
        tick(3);  chk("restart_lv", int'(lv1), 1);
                  chk("restart_d0", int'(data1), 0);
        tick(7);  chk("restart_d7", int'(data1), 7);

        // Randomized control: reference model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if ($urandom_range(0, 49) == 0) en1 = ~en1;
            if ($urandom_range(0, 199) == 0) en2 = ~en2;
            pat1 = 2'($urandom);
            pat2 = 2'($urandom);
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
